// File: rtl/bit_serial_operand_tx.sv
// Bit-serial operand transmitter: buffers parallel operand pairs, extends them to
// FRAME_W bits and shifts both out LSB-first with a frame-end clean strobe.
module bit_serial_operand_tx #(
  parameter int IN_W    = 8,
  parameter int FRAME_W = 32,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  input  logic             in_signed,
  output logic             a,
  output logic             b,
  output logic             clean,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BW = $clog2(FRAME_W);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] LAST = BW'(FRAME_W - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SHIFT} state_e;

  typedef struct packed {
    logic            sgn;
    logic [IN_W-1:0] a;
    logic [IN_W-1:0] b;
  } pair_t;

  function automatic logic [FRAME_W-1:0] ext(input logic [IN_W-1:0] x, input logic s);
    return {{(FRAME_W-IN_W){s & x[IN_W-1]}}, x};
  endfunction

  // operand-pair FIFO
  pair_t           mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            en_q;
  logic            push, pop;

  state_e          state_q;
  logic [BW-1:0]   bit_q, bit_inc;
  logic [FRAME_W-1:0] sa_q, sb_q, head_a, head_b;
  logic            a_q, b_q, clean_q, busy_q;
  logic [CNT_W-1:0] fcnt_q;
  pair_t           head;
  logic            last;

  // Ready only looks at the registered count; a same-cycle pop never frees a slot early.
  assign in_ready = en_q && (cnt_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign last     = (bit_q == LAST);
  assign pop      = (cnt_q != '0) && ((state_q == S_IDLE) || ((state_q == S_SHIFT) && last));
  assign head     = mem_q[rptr_q];
  assign head_a   = ext(head.a, head.sgn);
  assign head_b   = ext(head.b, head.sgn);
  assign bit_inc  = bit_q + BW'(1);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{sgn: in_signed, a: in_a, b: in_b};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Outputs are registered from the state being entered so bit 0 lands the cycle after a pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      en_q    <= 1'b0;
      bit_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      clean_q <= 1'b0;
      busy_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          state_q <= S_IDLE;
          en_q    <= 1'b1;
          clean_q <= 1'b1;
          a_q     <= 1'b0;
          b_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
        S_IDLE: begin
          clean_q <= 1'b0;
          if (pop) begin
            state_q <= S_SHIFT;
            bit_q   <= '0;
            sa_q    <= head_a;
            sb_q    <= head_b;
            a_q     <= head_a[0];
            b_q     <= head_b[0];
            busy_q  <= 1'b1;
          end else begin
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            busy_q <= (cnt_d != '0);
          end
        end
        S_SHIFT: begin
          if (last) begin
            fcnt_q  <= fcnt_q + CNT_W'(1);
            clean_q <= 1'b0;
            if (pop) begin
              bit_q  <= '0;
              sa_q   <= head_a;
              sb_q   <= head_b;
              a_q    <= head_a[0];
              b_q    <= head_b[0];
              busy_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              busy_q  <= (cnt_d != '0);
            end
          end else begin
            bit_q   <= bit_inc;
            a_q     <= sa_q[bit_inc];
            b_q     <= sb_q[bit_inc];
            clean_q <= (bit_inc == LAST);
            busy_q  <= 1'b1;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign clean     = clean_q;
  assign busy      = busy_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_bit_serial_operand_tx.sv
// Bench for bit_serial_operand_tx: cycle-exact frame-timeline model, a table of
// single-frame vectors, directed corner sequences and a serial-adder sweep.
module tb_bit_serial_operand_tx;
  localparam int IN_W = 8, FRAME_W = 32, DEPTH = 2, CNT_W = 16;

  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_signed = 1'b0;
  logic [IN_W-1:0] in_a = '0, in_b = '0;
  logic in_ready, a, b, clean, busy;
  logic [CNT_W-1:0] frame_cnt;

  bit_serial_operand_tx #(.IN_W(IN_W), .FRAME_W(FRAME_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .a(a), .b(b), .clean(clean), .busy(busy), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  // Each accepted pair becomes a frame occupying FRAME_W cycles from its start cycle.
  typedef struct {int push; int start; logic [31:0] xa; logic [31:0] xb;} frame_t;
  typedef struct {logic [7:0] a; logic [7:0] b; logic s; logic [31:0] ea; logic [31:0] eb;} vec_t;

  frame_t frames[$];
  vec_t   tab[6];
  int cur = 0, rel = 0, nchk = 0, nerr = 0;
  bit in_rst = 1'b1, armed = 1'b0;
  logic [31:0] sh_a = '0, sh_b = '0, sh_s = '0;
  logic carry = 1'b0;
  logic [31:0] mon_a[$], mon_b[$], mon_s[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cur, got, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [7:0] x, input logic s);
    if (s) return int'($signed(x));
    return {24'b0, x};
  endfunction

  function automatic int m_count(input int t);
    int n = 0;
    foreach (frames[i]) if (frames[i].push < t && frames[i].start > t) n++;
    return n;
  endfunction

  function automatic bit m_ready(input int t);
    return !in_rst && (t >= rel + 1) && (m_count(t) < DEPTH);
  endfunction

  task automatic check_cycle();
    logic ea = 0, eb = 0, ec = 0, ebusy = 0, s;
    int done = 0;
    logic [31:0] expv, act;
    if (!in_rst) begin
      ec = (cur == rel + 1);
      foreach (frames[i]) begin
        if (cur >= frames[i].start && cur < frames[i].start + FRAME_W) begin
          ea = frames[i].xa[cur - frames[i].start];
          eb = frames[i].xb[cur - frames[i].start];
          ebusy = 1'b1;
          if (cur == frames[i].start + FRAME_W - 1) ec = 1'b1;
        end
        if (frames[i].start + FRAME_W <= cur) done++;
      end
      if (m_count(cur) > 0) ebusy = 1'b1;
    end
    expv = {11'b0, ea, eb, ec, ebusy, m_ready(cur), 16'(done)};
    act  = {11'b0, a, b, clean, busy, in_ready, frame_cnt};
    chk("cycle{a,b,clean,busy,rdy,fcnt}", act, expv);
    // deserialiser plus a downstream bit-serial adder fed by the DUT outputs
    s = a ^ b ^ carry;
    sh_a = {a, sh_a[31:1]};
    sh_b = {b, sh_b[31:1]};
    sh_s = {s, sh_s[31:1]};
    carry = (a & b) | (a & carry) | (b & carry);
    if (clean) carry = 1'b0;
    if (clean && busy) begin
      mon_a.push_back(sh_a);
      mon_b.push_back(sh_b);
      mon_s.push_back(sh_s);
    end
  endtask

  task automatic tick();
    frame_t fr;
    if (in_valid && m_ready(cur)) begin
      fr.push  = cur;
      fr.start = cur + 2;
      if (frames.size() > 0 && frames[$].start + FRAME_W > fr.start)
        fr.start = frames[$].start + FRAME_W;
      fr.xa = ext(in_a, in_signed);
      fr.xb = ext(in_b, in_signed);
      frames.push_back(fr);
    end
    @(negedge clk);
    cur++;
    if (armed) check_cycle();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    in_rst = 1'b1;
    frames.delete();
    mon_a.delete(); mon_b.delete(); mon_s.delete();
    if (armed) begin
      #1;
      chk("rst_outputs_zero", {11'b0, a, b, clean, busy, in_ready, frame_cnt}, 32'h0);
    end
    armed = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    in_rst = 1'b0;
    rel = cur;
    tick();
    tick();
  endtask

  task automatic push_pair(input logic [7:0] pa, input logic [7:0] pb, input logic ps);
    bit acc;
    in_a = pa; in_b = pb; in_signed = ps; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      acc = m_ready(cur);
      tick();
      if (acc) return;
    end
    chk("push_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_mon(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < 3000 && mon_a.size() < n; k++) tick();
    chk("frames_seen", mon_a.size(), n);
  endtask

  initial begin
    tab[0] = '{8'hF6, 8'h03, 1'b1, 32'hFFFFFFF6, 32'h00000003};
    tab[1] = '{8'h80, 8'hFF, 1'b0, 32'h00000080, 32'h000000FF};
    tab[2] = '{8'h80, 8'h7F, 1'b1, 32'hFFFFFF80, 32'h0000007F};
    tab[3] = '{8'hFF, 8'hFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tab[4] = '{8'h00, 8'h01, 1'b0, 32'h00000000, 32'h00000001};
    tab[5] = '{8'h5A, 8'hA5, 1'b0, 32'h0000005A, 32'h000000A5};

    #2;
    do_reset();
    chk("ready_after_init", in_ready, 1'b1);

    // table of single frames, each deserialised and compared
    for (int i = 0; i < 6; i++) begin
      push_pair(tab[i].a, tab[i].b, tab[i].s);
      wait_mon(1);
      if (mon_a.size() > 0) begin
        chk("tab_a", mon_a.pop_front(), tab[i].ea);
        chk("tab_b", mon_b.pop_front(), tab[i].eb);
        void'(mon_s.pop_front());
      end
      idle(3);
    end
    chk("tab_frame_cnt", frame_cnt, 16'd6);

    // back-to-back frames with in_valid held
    do_reset();
    push_pair(8'd1, 8'd2, 1'b0);
    push_pair(8'd3, 8'd4, 1'b0);
    push_pair(8'd5, 8'd6, 1'b0);
    in_valid = 1'b0;
    chk("b2b_full_ready", in_ready, 1'b0);
    wait_mon(3);
    idle(2);
    chk("b2b_frame_cnt", frame_cnt, 16'd3);
    for (int i = 0; i < 3 && mon_a.size() > 0; i++) begin
      chk("b2b_a", mon_a.pop_front(), 32'(2 * i + 1));
      chk("b2b_b", mon_b.pop_front(), 32'(2 * i + 2));
    end

    // idle gap between two frames
    do_reset();
    push_pair(8'h11, 8'h22, 1'b0);
    idle(40);
    push_pair(8'h33, 8'h44, 1'b1);
    wait_mon(2);
    idle(2);

    // reset during bit 10 of a frame with another pair buffered
    do_reset();
    push_pair(8'hC3, 8'h3C, 1'b1);
    push_pair(8'h0F, 8'hF0, 1'b0);
    in_valid = 1'b0;
    for (int k = 0; k < 100 && frames.size() > 0 && cur != frames[0].start + 10; k++) tick();
    chk("at_bit10", cur, frames.size() > 0 ? frames[0].start + 10 : -1);
    do_reset();
    idle(40);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    chk("rst_ready", in_ready, 1'b1);

    // adder sweep, all pairs back-to-back
    do_reset();
    for (int x = -10; x <= 9; x++)
      for (int y = -10; y <= 9; y++)
        push_pair(8'(x), 8'(y), 1'b1);
    wait_mon(400);
    begin
      int k = 0;
      for (int x = -10; x <= 9; x++)
        for (int y = -10; y <= 9; y++) begin
          if (k < mon_s.size()) chk("adder_sum", mon_s[k], 32'(x + y));
          k++;
        end
    end
    idle(2);

    // randomized traffic checked by the per-cycle model
    do_reset();
    for (int i = 0; i < 200; i++) begin
      push_pair(8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 40));
    end
    idle(100);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/bit_serial_operand_tx.md
Name: bit_serial_operand_tx

Overview:
- Transmit side of the bit-serial arithmetic interface: accepts parallel operand pairs over a valid/ready handshake.
- Sign- or zero-extends each pair to the frame width and shifts both operands out LSB-first on the serial a/b lines.
- Drives the frame-end clean strobe so the downstream bit-serial adder clears its carry between frames.
- Buffers operand pairs so consecutive frames go out back-to-back with no bubble cycles.

Parameters:
- IN_W, 8: width of each parallel operand.
- FRAME_W, 32: serial frame length in bits; must be greater than IN_W.
- DEPTH, 2: operand-pair FIFO entries (power of 2, at least 2).
- CNT_W, 16: width of the frame counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  FIFO can accept a pair this cycle.
- in_a  in  IN_W  operand A; serialised onto a.
- in_b  in  IN_W  operand B; serialised onto b.
- in_signed  in  1  1 = sign-extend the pair, 0 = zero-extend; captured per pair.
- a  out  1  serial operand A, LSB first.
- b  out  1  serial operand B, LSB first.
- clean  out  1  high on the cycle carrying bit FRAME_W-1, and on the init cycle.
- busy  out  1  a frame is shifting or the FIFO is non-empty.
- frame_cnt  out  CNT_W  number of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied, FSM goes to INIT.
  - a=b=clean=0, busy=0, frame_cnt=0, in_ready=0.
  - A reset mid-frame abandons that frame; no remaining bits and no clean are emitted for it.
- FSM states INIT, IDLE, SHIFT:
  - INIT: lasts exactly one cycle after reset releases. clean=1, a=b=0. Then goes to IDLE; in_ready becomes 1.
  - IDLE: a=b=clean=0. When the FIFO is non-empty, pop the head into the A/B shift registers, load bit_cnt=0, go to SHIFT.
  - SHIFT: a=sa[bit_cnt], b=sb[bit_cnt]. bit_cnt increments each cycle.
  - SHIFT, bit_cnt==FRAME_W-1: clean=1 and frame_cnt increments.
    - FIFO non-empty: pop the next pair, stay in SHIFT, and bit 0 of the new frame appears the very next cycle (zero bubble).
    - FIFO empty: go to IDLE.
- Extension: for bit index i >= IN_W, the output bit is in_x[IN_W-1] when the captured in_signed=1, else 0.
- Registered outputs: a, b, clean and busy are flops.
- Handshake:
  - A push happens when in_valid && in_ready at a rising edge.
  - in_ready = (FIFO count < DEPTH); it is combinational from the registered count only, with no bypass.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - With the FIFO full, in_ready=0 even if a pop happens that cycle.
  - in_valid while in_ready=0 is ignored; the source holds the data.
- Latency:
  - A pair accepted at the edge ending cycle n, with the FSM idle, puts bit 0 on a/b in cycle n+2.
  - Bit i appears in cycle n+2+i; clean appears in cycle n+1+FRAME_W.
- Sustained throughput: one pair per FRAME_W cycles. With DEPTH=2, in_ready drops once one pair is shifting and two are buffered.
- busy = (state==SHIFT) || (count!=0).
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Single signed pair:
  - Stimulus: release reset, then in_a=-10 (0xF6), in_b=3, in_signed=1.
  - Required: one INIT clean pulse; a deserialises to 0xFFFFFFF6 and b to 0x00000003; clean is high only with bit 31; frame_cnt=1; then IDLE with a=b=0.
- Unsigned extension:
  - Stimulus: in_a=0x80, in_b=0xFF, in_signed=0.
  - Required: a=0x00000080, b=0x000000FF.
- Back-to-back:
  - Stimulus: in_valid held with pairs (1,2), (3,4), (5,6).
  - Required: 96 contiguous bit cycles with clean at bit cycles 31, 63 and 95 only; in_ready=0 while two pairs are buffered; frame_cnt=3; busy drops the cycle after the final clean.
- Idle gap:
  - Stimulus: one pair, 40 idle cycles, a second pair.
  - Required: a=b=clean=0 throughout the gap; the second frame has the exact n+2 latency.
- Reset mid-frame:
  - Stimulus: assert reset at bit 10 of a frame with one pair buffered.
  - Required: outputs are 0 immediately; after release, one clean cycle, FIFO empty, frame_cnt=0, in_ready=1; nothing further is emitted until a new push.
- End-to-end with the downstream adder:
  - Stimulus: sweep all a,b in -10..9, signed, back-to-back.
  - Required: all 400 deserialised sums equal a+b, for example -10 + -10 = -20 (0xFFFFFFEC).
